// File: rtl/barrel_spawner.sv
`default_nettype none
// ============================================================================
// Module   : barrel_spawner
// Brief    : Schedules barrel launches. Waits a jittered interval, requests a
//            donkey throw, then pulses one free barrel-mover slot. The slot is
//            chosen round-robin from a rotating pointer.
// Revision : 1.0 - initial release
// ============================================================================
module barrel_spawner #(
    parameter int NUM_SLOTS    = 4,
    parameter int SPAWN_PERIOD = 65_000_000,
    parameter int THROW_TIME   = 32_500_000,
    parameter int JITTER_UNIT  = 4_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 pause,
    input  logic [NUM_SLOTS-1:0] done,
    output logic [NUM_SLOTS-1:0] barrel,
    output logic                 throw,
    output logic [2:0]           active_cnt,
    output logic [7:0]           spawn_cnt
);

    localparam int                 C_CNT_W      = 27;
    localparam int                 C_PTR_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [C_CNT_W-1:0] C_THROW_LAST = C_CNT_W'(THROW_TIME - 1);
    localparam logic [C_CNT_W-1:0] C_WAIT_BASE  = C_CNT_W'(SPAWN_PERIOD - 1);
    localparam logic [C_CNT_W-1:0] C_JIT_UNIT   = C_CNT_W'(JITTER_UNIT);
    localparam logic [7:0]         C_LFSR_SEED  = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_THROW  = 2'd2,
        ST_LAUNCH = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [C_CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0]   busy_q, busy_d;
    logic [NUM_SLOTS-1:0]   done_q, done_d;
    logic [C_PTR_W-1:0]     ptr_q, ptr_d;
    logic [C_PTR_W-1:0]     sel_q, sel_d;
    logic [7:0]             lfsr_q, lfsr_d;
    logic [7:0]             spawn_q, spawn_d;
    logic [2:0]             active_q, active_d;
    logic [NUM_SLOTS-1:0]   barrel_q, barrel_d;
    logic                   throw_q, throw_d;

    logic [NUM_SLOTS-1:0]   done_edge;
    logic                   any_free;
    logic                   pick_found;
    logic [C_PTR_W-1:0]     pick_idx;
    logic [C_CNT_W-1:0]     wait_term;
    logic                   lfsr_fb;

    // Slot index modulo NUM_SLOTS, used by the round-robin scan
    function automatic logic [C_PTR_W-1:0] wrap_idx(input int v);
        return C_PTR_W'(v % NUM_SLOTS);
    endfunction

    // Round-robin search for the first free slot starting at the pointer
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (!pick_found && !busy_q[wrap_idx(int'(ptr_q) + k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_idx(int'(ptr_q) + k);
            end
        end
    end

    // Busy-slot population count, registered so it trails busy by one cycle
    always_comb begin
        active_d = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            active_d = active_d + 3'(busy_q[k]);
        end
    end

    // Next-state, counter, slot bookkeeping and registered output values
    always_comb begin
        done_edge = done & ~done_q;
        any_free  = ~(&busy_q);
        lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        wait_term = C_WAIT_BASE + C_CNT_W'(lfsr_q[3:0]) * C_JIT_UNIT;

        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = done;
        busy_d   = busy_q & ~done_edge;   // done edges on idle slots are no-ops
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        lfsr_d   = lfsr_q;
        spawn_d  = spawn_q;
        barrel_d = '0;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (!pause) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
                ST_WAIT: begin
                    // Interval expired: leave only when a slot is free, else park
                    if (cnt_q >= wait_term) begin
                        if (any_free) begin
                            state_d = ST_THROW;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_THROW: begin
                    if (cnt_q >= C_THROW_LAST) begin
                        state_d = ST_LAUNCH;
                        cnt_d   = '0;
                        sel_d   = pick_idx;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    barrel_d[sel_q] = 1'b1;
                    busy_d[sel_q]   = 1'b1;
                    ptr_d           = wrap_idx(int'(sel_q) + 1);
                    spawn_d         = spawn_q + 8'd1;
                    lfsr_d          = {lfsr_q[6:0], lfsr_fb};
                    state_d         = ST_WAIT;
                    cnt_d           = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        throw_d = (state_d == ST_THROW);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= '0;
            done_q   <= '0;
            ptr_q    <= '0;
            sel_q    <= '0;
            lfsr_q   <= C_LFSR_SEED;
            spawn_q  <= '0;
            active_q <= '0;
            barrel_q <= '0;
            throw_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            lfsr_q   <= lfsr_d;
            spawn_q  <= spawn_d;
            active_q <= active_d;
            barrel_q <= barrel_d;
            throw_q  <= throw_d;
        end
    end

    assign barrel     = barrel_q;
    assign throw      = throw_q;
    assign active_cnt = active_q;
    assign spawn_cnt  = spawn_q;

endmodule
`default_nettype wire

// File: tb/tb_barrel_spawner.sv
`default_nettype none
// ============================================================================
// Module   : tb_barrel_spawner
// Brief    : Scoreboard bench for barrel_spawner. Instance 0 (no jitter) runs
//            directed scenarios; instance 1 (unit jitter) runs random done
//            traffic. Expected launches are queued when stimulus is planned
//            and popped by a negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_barrel_spawner;

    logic       clk = 1'b0;
    logic       rst0, rst1, en0, en1, pause0, pause1;
    logic [3:0] done0, done1, barrel0, barrel1;
    logic       throw0, throw1;
    logic [2:0] active0, active1;
    logic [7:0] spawn0, spawn1;

    barrel_spawner #(.NUM_SLOTS(4), .SPAWN_PERIOD(10), .THROW_TIME(4), .JITTER_UNIT(0)) u_dut (
        .clk(clk), .rst(rst0), .enable(en0), .pause(pause0), .done(done0),
        .barrel(barrel0), .throw(throw0), .active_cnt(active0), .spawn_cnt(spawn0));

    barrel_spawner #(.NUM_SLOTS(4), .SPAWN_PERIOD(10), .THROW_TIME(4), .JITTER_UNIT(1)) u_jit (
        .clk(clk), .rst(rst1), .enable(en1), .pause(pause1), .done(done1),
        .barrel(barrel1), .throw(throw1), .active_cnt(active1), .spawn_cnt(spawn1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int slot;
        int spawn;
        int act;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: slot occupancy, round-robin pointer, launch count, LFSR
    logic [3:0] busy_m [2];
    int         ptr_m  [2];
    int         spawn_m[2];
    logic [7:0] lfsr_m [2];
    logic [3:0] dlev_m [2];
    int         unit_m [2] = '{0, 1};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic int wlen(input int i);
        return 10 + unit_m[i] * int'(lfsr_m[i][3:0]);
    endfunction

    task automatic model_reset(input int i);
        busy_m[i]  = '0;
        ptr_m[i]   = 0;
        spawn_m[i] = 0;
        lfsr_m[i]  = 8'hA5;
        dlev_m[i]  = '0;
    endtask

    // Drive the done levels; a rising level frees the slot if it was occupied
    task automatic set_done(input int i, input logic [3:0] v);
        for (int s = 0; s < 4; s++) begin
            if (v[s] && !dlev_m[i][s]) busy_m[i][s] = 1'b0;
        end
        dlev_m[i] = v;
        if (i == 0) done0 = v;
        else        done1 = v;
    endtask

    // Throw starts at cycle x; the barrel pulse becomes visible five cycles later
    task automatic expect_launch(input int i, input int x);
        exp_t e;
        int   slot;
        slot = -1;
        for (int k = 0; k < 4; k++) begin
            if (slot < 0 && !busy_m[i][(ptr_m[i] + k) % 4]) slot = (ptr_m[i] + k) % 4;
        end
        e.cyc   = x + 5;
        e.slot  = slot;
        e.spawn = (spawn_m[i] + 1) % 256;
        e.act   = $countones(busy_m[i]);
        if (slot >= 0) begin
            busy_m[i][slot] = 1'b1;
            ptr_m[i]        = (slot + 1) % 4;
        end
        spawn_m[i] = spawn_m[i] + 1;
        lfsr_m[i]  = lfsr_step(lfsr_m[i]);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int i, input logic [3:0] b, input int sp, input int ac);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (i == 0 && q0.size() > 0 && (b != 0 || q0[0].cyc <= cyc)) begin
            e = q0.pop_front(); have = 1'b1;
        end
        if (i == 1 && q1.size() > 0 && (b != 0 || q1[0].cyc <= cyc)) begin
            e = q1.pop_front(); have = 1'b1;
        end
        if (have) begin
            chk($sformatf("inst%0d launch_cycle", i), cyc, e.cyc);
            chk($sformatf("inst%0d barrel", i), int'(b), (e.slot >= 0) ? (1 << e.slot) : 0);
            chk($sformatf("inst%0d spawn_cnt", i), sp, e.spawn);
            chk($sformatf("inst%0d active_cnt", i), ac, e.act);
        end else if (b != 0) begin
            chk($sformatf("inst%0d unexpected_barrel", i), int'(b), 0);
        end
    endtask

    // Monitor: compares every presented barrel pulse with the scoreboard head
    always @(negedge clk) begin
        mon(0, barrel0, int'(spawn0), int'(active0));
        mon(1, barrel1, int'(spawn1), int'(active1));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         e_c;
        int         x;
        int         d;
        int         w;
        int         o;
        int         s;
        logic [3:0] pv [0:31];

        rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
        pause0 = 1'b0; pause1 = 1'b0; done0 = '0; done1 = '0;
        model_reset(0);
        model_reset(1);
        repeat (3) tick();
        rst0 = 1'b0; rst1 = 1'b0;
        tick();

        chk("rst barrel0", int'(barrel0), 0);
        chk("rst throw0", int'(throw0), 0);
        chk("rst active0", int'(active0), 0);
        chk("rst spawn0", int'(spawn0), 0);
        chk("rst throw1", int'(throw1), 0);
        chk("rst spawn1", int'(spawn1), 0);

        // done edge on an idle slot changes nothing
        set_done(0, 4'b0010); tick(); set_done(0, 4'b0000); tick(); tick();
        chk("idle_done active0", int'(active0), 0);

        // first launch and throw window
        en0 = 1'b1;
        e_c = cyc + 1;
        x = e_c + wlen(0);
        expect_launch(0, x);
        wait_until(x - 1); chk("throw before window", int'(throw0), 0);
        tick();            chk("throw first cycle", int'(throw0), 1);
        wait_until(x + 3); chk("throw last cycle", int'(throw0), 1);
        tick();            chk("throw after window", int'(throw0), 0);
        e_c = x + 5;

        // slots 1..3 fill in order
        for (int k = 1; k < 4; k++) begin
            x = e_c + wlen(0);
            expect_launch(0, x);
            e_c = x + 5;
        end

        // fifth interval parks until done[2] rises
        wait_until(e_c + 19); chk("active all busy", int'(active0), 4);
        tick();
        set_done(0, 4'b0100);
        x = cyc + 2;
        expect_launch(0, x);
        tick(); set_done(0, 4'b0000);
        tick(); chk("active after done2", int'(active0), 3);
        e_c = x + 5;

        // done[0] held high frees slot 0 exactly once
        wait_until(e_c + 2);
        set_done(0, 4'b0001);
        x = e_c + wlen(0);
        expect_launch(0, x);
        wait_until(e_c + 5); chk("active held done dec", int'(active0), 3);
        e_c = x + 5;
        wait_until(e_c + 40); chk("active held done once", int'(active0), 4);

        // done[1] frees slot 1, then a second rise on the now-idle slot is ignored
        set_done(0, 4'b0011);
        d = cyc;
        x = d + 2;
        tick(); set_done(0, 4'b0001);
        tick(); set_done(0, 4'b0011);
        expect_launch(0, x);
        tick(); set_done(0, 4'b0000);
        wait_until(d + 5); chk("active idle done ignored", int'(active0), 3);
        e_c = x + 5;

        // pause 20 cycles at WAIT count 5
        wait_until(e_c + 1); set_done(0, 4'b1000); tick(); set_done(0, 4'b0000);
        wait_until(e_c + 5);
        pause0 = 1'b1;
        x = e_c + wlen(0) + 20;
        expect_launch(0, x);
        wait_until(e_c + 15); chk("throw during pause", int'(throw0), 0);
        wait_until(e_c + 25); pause0 = 1'b0;
        e_c = x + 5;

        // enable dropped during throw: no launch, full wait after re-enable
        wait_until(e_c + 1); set_done(0, 4'b0001); tick(); set_done(0, 4'b0000);
        x = e_c + wlen(0);
        wait_until(x + 1); chk("throw before drop", int'(throw0), 1);
        en0 = 1'b0;
        tick(); chk("throw after drop", int'(throw0), 0);
        wait_until(x + 6);
        en0 = 1'b1;
        e_c = cyc + 1;
        x = e_c + wlen(0);
        expect_launch(0, x);
        wait_until(e_c + 9); chk("rearm throw idle", int'(throw0), 0);
        tick();              chk("rearm throw start", int'(throw0), 1);
        e_c = x + 5;

        // reset during the launch cycle aborts the pulse
        wait_until(e_c + 1); set_done(0, 4'b0010); tick(); set_done(0, 4'b0000);
        x = e_c + wlen(0);
        wait_until(x + 4);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        model_reset(0);
        chk("launch rst barrel", int'(barrel0), 0);
        chk("launch rst spawn", int'(spawn0), 0);
        chk("launch rst active", int'(active0), 0);
        chk("launch rst throw", int'(throw0), 0);
        wait_until(x + 8);
        en0 = 1'b0;

        // random done traffic against the jittered instance
        en1 = 1'b1;
        e_c = cyc + 1;
        for (int n = 0; n < 24; n++) begin
            w = wlen(1);
            for (int j = 0; j < 32; j++) pv[j] = '0;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(1, 0) == 1) begin
                    o = int'($urandom_range(w - 4, 1));
                    pv[o][k] = 1'b1;
                end
            end
            for (int j = 1; j <= w - 4; j++) begin
                wait_until(e_c + j);
                set_done(1, pv[j]);
            end
            wait_until(e_c + w - 3);
            set_done(1, 4'b0000);
            if (&busy_m[1]) begin
                wait_until(e_c + w - 1 + int'($urandom_range(4, 0)));
                s = int'($urandom_range(3, 0));
                set_done(1, 4'(1 << s));
                x = cyc + 2;
                tick();
                set_done(1, 4'b0000);
            end else begin
                x = e_c + w;
            end
            expect_launch(1, x);
            e_c = x + 5;
        end
        wait_until(e_c + 2);
        en1 = 1'b0;
        repeat (4) tick();

        chk("inst0 launches outstanding", q0.size(), 0);
        chk("inst1 launches outstanding", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
